// File: rtl/beep_sequencer.sv
// Melody sequencer: walks a song ROM of {note[7:3], beats[2:0]} entries and drives pwm cycle/duty.
// Define BEEP_SEQ_LOOP_EN to wrap back to address 0 at song end instead of stopping.
module beep_sequencer #(
    parameter int WIDTH       = 32,
    parameter int CLK_HZ      = 12_000_000,
    parameter int BEAT_CYCLES = 3_000_000,
    parameter int GAP_CYCLES  = 120_000,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [WIDTH-1:0]  cycle,
    output logic [WIDTH-1:0]  duty,
    output logic [4:0]        note_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_END
    } state_t;

    localparam logic [WIDTH-1:0]  GAP_LOAD  = (GAP_CYCLES == 0) ? '0 : WIDTH'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t           state;
    logic [WIDTH-1:0] count;
    logic [4:0]       rom_note;
    logic [2:0]       rom_beats;
    logic [WIDTH-1:0] rom_cycle;

    assign rom_note  = rom_data[7:3];
    assign rom_beats = rom_data[2:0];

    // Period in clks for each note code; unused codes are rests (period 0).
    always_comb begin
        rom_cycle = '0;
        case (rom_note)
            5'd1:  rom_cycle = WIDTH'(CLK_HZ / 131);
            5'd2:  rom_cycle = WIDTH'(CLK_HZ / 147);
            5'd3:  rom_cycle = WIDTH'(CLK_HZ / 165);
            5'd4:  rom_cycle = WIDTH'(CLK_HZ / 175);
            5'd5:  rom_cycle = WIDTH'(CLK_HZ / 196);
            5'd6:  rom_cycle = WIDTH'(CLK_HZ / 220);
            5'd7:  rom_cycle = WIDTH'(CLK_HZ / 247);
            5'd8:  rom_cycle = WIDTH'(CLK_HZ / 262);
            5'd9:  rom_cycle = WIDTH'(CLK_HZ / 294);
            5'd10: rom_cycle = WIDTH'(CLK_HZ / 330);
            5'd11: rom_cycle = WIDTH'(CLK_HZ / 349);
            5'd12: rom_cycle = WIDTH'(CLK_HZ / 392);
            5'd13: rom_cycle = WIDTH'(CLK_HZ / 440);
            5'd14: rom_cycle = WIDTH'(CLK_HZ / 494);
            5'd15: rom_cycle = WIDTH'(CLK_HZ / 523);
            5'd16: rom_cycle = WIDTH'(CLK_HZ / 587);
            5'd17: rom_cycle = WIDTH'(CLK_HZ / 659);
            5'd18: rom_cycle = WIDTH'(CLK_HZ / 698);
            5'd19: rom_cycle = WIDTH'(CLK_HZ / 784);
            5'd20: rom_cycle = WIDTH'(CLK_HZ / 880);
            5'd21: rom_cycle = WIDTH'(CLK_HZ / 988);
            default: rom_cycle = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (!rst_n) begin
            state    <= S_IDLE;
            count    <= '0;
            rom_addr <= '0;
            cycle    <= '0;
            duty     <= '0;
            note_idx <= '0;
            busy     <= 1'b0;
        end else if (stop && state != S_IDLE) begin
            // Abort silences everything, including the held period.
            state    <= S_IDLE;
            count    <= '0;
            rom_addr <= '0;
            cycle    <= '0;
            duty     <= '0;
            note_idx <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    rom_addr <= '0;
                    duty     <= '0;
                    if (start && !stop) begin
                        busy  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    if (rom_beats == 3'd0) begin
`ifdef BEEP_SEQ_LOOP_EN
                        rom_addr <= '0;
                        state    <= S_FETCH;
`else
                        rom_addr <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_END;
`endif
                    end else begin
                        cycle    <= rom_cycle;
                        duty     <= rom_cycle >> 1;
                        note_idx <= (rom_cycle == '0) ? 5'd0 : rom_note;
                        count    <= WIDTH'(rom_beats) * WIDTH'(BEAT_CYCLES) - WIDTH'(1);
                        state    <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (count == '0) begin
                        duty     <= '0;
                        note_idx <= '0;
                        count    <= GAP_LOAD;
                        state    <= S_GAP;
                    end else begin
                        count <= count - WIDTH'(1);
                    end
                end
                S_GAP: begin
                    if (count == '0) begin
                        if (rom_addr == LAST_ADDR) begin
`ifdef BEEP_SEQ_LOOP_EN
                            rom_addr <= '0;
                            state    <= S_FETCH;
`else
                            rom_addr <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_END;
`endif
                        end else begin
                            rom_addr <= rom_addr + ADDR_W'(1);
                            state    <= S_FETCH;
                        end
                    end else begin
                        count <= count - WIDTH'(1);
                    end
                end
                S_END: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beep_sequencer.sv
// Bench for beep_sequencer: directed scenarios, per-cycle compare against a song-timeline model.
module tb_beep_sequencer;

    localparam int WIDTH       = 32;
    localparam int CLK_HZ      = 12_000_000;
    localparam int BEAT_CYCLES = 10;
    localparam int GAP_CYCLES  = 2;
    localparam int ADDR_W      = 3;
    localparam int EW          = 74;
    localparam int MAXN        = 160;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop  = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [WIDTH-1:0]  cycle;
    logic [WIDTH-1:0]  duty;
    logic [4:0]        note_idx;
    logic              busy;
    logic              done;

    logic [7:0] rom [8];

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    beep_sequencer #(
        .WIDTH       (WIDTH),
        .CLK_HZ      (CLK_HZ),
        .BEAT_CYCLES (BEAT_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .cycle    (cycle),
        .duty     (duty),
        .note_idx (note_idx),
        .busy     (busy),
        .done     (done)
    );

    // Expected record: {cycle, duty, note_idx, busy, done, rom_addr}
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] nat_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    string         scn_name = "none";
    logic          st_v [MAXN];
    logic          sp_v [MAXN];
    logic          rs_v [MAXN];
    logic [31:0]   m_cycle = 32'd0;
    bit            m_play = 1'b0;

    function automatic logic [31:0] model_cycle(input int code);
        int freq [22];
        freq = '{0, 131, 147, 165, 175, 196, 220, 247,
                 262, 294, 330, 349, 392, 440, 494,
                 523, 587, 659, 698, 784, 880, 988};
        if (code < 1 || code > 21) return 32'd0;
        return 32'(CLK_HZ / freq[code]);
    endfunction

    function automatic logic [EW-1:0] mk(input logic [31:0] c, input logic [31:0] d,
                                         input logic [4:0] ni, input logic b,
                                         input logic dn, input logic [2:0] a);
        return {c, d, ni, b, dn, a};
    endfunction

    // Full timeline of one play-through, one entry per clock after the start edge.
    task automatic build_song(input logic [31:0] c0, input int cap);
        logic [31:0] c;
        int          a;
        bit          fin;
        logic [4:0]  nt;
        int          b;
        c   = c0;
        a   = 0;
        fin = 1'b0;
        nat_q.delete();
        while (!fin && nat_q.size() < cap) begin
            nat_q.push_back(mk(c, 32'd0, 5'd0, 1'b1, 1'b0, 3'(a)));
            nat_q.push_back(mk(c, 32'd0, 5'd0, 1'b1, 1'b0, 3'(a)));
            nt = rom[a][7:3];
            b  = int'(rom[a][2:0]);
            if (b != 0) begin
                c = model_cycle(int'(nt));
                repeat (b * BEAT_CYCLES)
                    nat_q.push_back(mk(c, c >> 1, (c != 32'd0) ? nt : 5'd0, 1'b1, 1'b0, 3'(a)));
                repeat ((GAP_CYCLES == 0) ? 1 : GAP_CYCLES)
                    nat_q.push_back(mk(c, 32'd0, 5'd0, 1'b1, 1'b0, 3'(a)));
            end
            if (b == 0 || a == 7) begin
`ifdef BEEP_SEQ_LOOP_EN
                a = 0;
`else
                nat_q.push_back(mk(c, 32'd0, 5'd0, 1'b0, 1'b1, 3'd0));
                fin = 1'b1;
`endif
            end else begin
                a++;
            end
        end
    endtask

    task automatic clr();
        for (int i = 0; i < MAXN; i++) begin
            st_v[i] = 1'b0;
            sp_v[i] = 1'b0;
            rs_v[i] = 1'b1;
        end
    endtask

    task automatic pin(input string nm, input logic [EW-1:0] got, input logic [EW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL pin %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic run_scn(input string nm, input int n);
        int            p;
        logic [EW-1:0] e;
        @(negedge clk);
        #1;
        scn_name = nm;
        p = 0;
        for (int i = 0; i < n; i++) begin
            if (!rs_v[i] || (sp_v[i] && m_play)) begin
                exp_q.push_back(mk(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd0));
                m_play  = 1'b0;
                m_cycle = 32'd0;
            end else begin
                if (st_v[i] && !sp_v[i] && !m_play) begin
                    build_song(m_cycle, n);
                    p      = 0;
                    m_play = 1'b1;
                end
                if (m_play && p < nat_q.size()) begin
                    e = nat_q[p];
                    p++;
                end else begin
                    m_play = 1'b0;
                    e = mk(m_cycle, 32'd0, 5'd0, 1'b0, 1'b0, 3'd0);
                end
                exp_q.push_back(e);
                m_cycle = e[73:42];
            end
        end
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            rst_n = rs_v[i];
            start = st_v[i];
            stop  = sp_v[i];
        end
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [EW-1:0] got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {cycle, duty, note_idx, busy, done, rom_addr};
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL %s t=%0t: got cycle=%0d duty=%0d note=%0d busy=%b done=%b addr=%0d | want cycle=%0d duty=%0d note=%0d busy=%b done=%b addr=%0d",
                         scn_name, $time, cycle, duty, note_idx, busy, done, rom_addr,
                         e[73:42], e[41:10], e[9:5], e[4], e[3], e[2:0]);
            end
        end
    end

    initial begin
        rom = '{8'h42, 8'h7A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        // Hand-computed note periods and timeline entries that pin the model.
        pin("cyc_low_c",  EW'(model_cycle(1)),  EW'(91603));
        pin("cyc_mid_c",  EW'(model_cycle(8)),  EW'(45801));
        pin("cyc_mid_b",  EW'(model_cycle(14)), EW'(24291));
        pin("cyc_high_c", EW'(model_cycle(15)), EW'(22944));
        pin("cyc_high_b", EW'(model_cycle(21)), EW'(12145));
        pin("cyc_rest0",  EW'(model_cycle(0)),  EW'(0));
        pin("cyc_rest22", EW'(model_cycle(22)), EW'(0));
        build_song(32'd0, 1000);
        pin("song_first_tone",  nat_q[2],  mk(32'd45801, 32'd22900, 5'd8, 1'b1, 1'b0, 3'd0));
        pin("song_last_tone",   nat_q[21], mk(32'd45801, 32'd22900, 5'd8, 1'b1, 1'b0, 3'd0));
        pin("song_first_gap",   nat_q[22], mk(32'd45801, 32'd0, 5'd0, 1'b1, 1'b0, 3'd0));
        pin("song_second_tone", nat_q[26], mk(32'd22944, 32'd11472, 5'd15, 1'b1, 1'b0, 3'd1));
`ifndef BEEP_SEQ_LOOP_EN
        pin("song_len", EW'(nat_q.size()), EW'(51));
        pin("song_end", nat_q[50], mk(32'd22944, 32'd0, 5'd0, 1'b0, 1'b1, 3'd0));
`endif

        clr();
        rs_v[0] = 1'b0;
        rs_v[1] = 1'b0;
        run_scn("reset", 2);

        clr();
        st_v[1] = 1'b1;
        run_scn("two_notes", 60);

        rom = '{8'h03, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        clr();
        st_v[0] = 1'b1;
        run_scn("rest_entry", 60);

        rom = '{8'h42, 8'h7A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        clr();
        st_v[0]  = 1'b1;
        sp_v[7]  = 1'b1;
        st_v[10] = 1'b1;
        run_scn("stop_restart", 70);

        clr();
        st_v[0]  = 1'b1;
        st_v[8]  = 1'b1;
        st_v[15] = 1'b1;
        sp_v[15] = 1'b1;
        st_v[20] = 1'b1;
        sp_v[20] = 1'b1;
        run_scn("start_ignored_stop_wins", 25);

        rom = '{8'h09, 8'h41, 8'h79, 8'hA9, 8'hF9, 8'h71, 8'h11, 8'h59};
        clr();
        st_v[0] = 1'b1;
        run_scn("full_rom_no_marker", 125);

        rom = '{8'h42, 8'h7A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        clr();
        st_v[0] = 1'b1;
        rs_v[6] = 1'b0;
        st_v[8] = 1'b1;
        run_scn("reset_mid_note", 40);

        @(negedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
